fp_comp_responder: RTL and testbench
====================================

// Module: fp_comp_responder
// PURPOSE
//  Slave-side single-precision compare unit answering the FPU dispatcher's comp channel
//  (FEQ.S/FLT.S/FLE.S). Joins three AXI-stream input channels (a, b, op), evaluates an
//  IEEE-754 compare in a stall-able pipeline, returns the 0/1 result on the r channel.
//  Pin-compatible drop-in for the vendor compare core; lets sim and ASIC flows run without IP.
// PARAMETERS
//  LATENCY   2   pipeline stages from operand join to r_tvalid; legal 1..8
// PORTS
//  CLK             in   1   clock
//  RST_N           in   1   synchronous reset, active-low
//  comp_a_tdata    in   32  operand A (binary32)
//  comp_a_tvalid   in   1   A valid
//  comp_a_tready   out  1   A accepted when valid&ready
//  comp_b_tdata    in   32  operand B (binary32)
//  comp_b_tvalid   in   1   B valid
//  comp_b_tready   out  1   B accepted when valid&ready
//  comp_op_tdata   in   8   op code: 0x14 EQ, 0x0C LT, 0x1C LE (bits[7:6] ignored)
//  comp_op_tvalid  in   1   op valid
//  comp_op_tready  out  1   op accepted when valid&ready
//  comp_r_tdata    out  32  {31'b0, result}
//  comp_r_tvalid   out  1   result valid; held until accepted
//  comp_r_tready   in   1   consumer ready
// BEHAVIOUR
//  Reset (RST_N=0 at posedge): all holding regs empty, all pipe valids 0, r_tdata=0,
//   r_tvalid=0; in-flight operations discarded, no result emitted for them.
//  Input join: one-entry holding reg per channel (a_full, b_full, op_full), filled
//   independently on valid&ready. Channels may arrive in any order/cycle.
//  fire = a_full & b_full & op_full & adv; on fire all three regs empty in that cycle.
//  x_tready = !x_full | fire (combinational); back-to-back beats give 1 op/cycle.
//  adv = !(stage[LATENCY-1] valid & !comp_r_tready); when adv=0 whole pipe holds.
//  Bubbles propagate; stage k valid <= stage k-1 valid when adv.
//  Latency: all channels present at cycle N with r_tready=1 -> r_tvalid at N+LATENCY.
//  r_tvalid/r_tdata come straight from last stage regs; stable while r_tready=0.
//  Compare (computed in stage 0, carried down):
//   NaN: exp==8'hFF & mant!=0 (quiet or signalling); unordered = NaN(A)|NaN(B).
//   Order key: sign ? ~x : x|32'h80000000, compared unsigned; both zeros map to equal
//    (mag(A)==0 & mag(B)==0 -> equal, lt false).
//   EQ: !unordered & equal. LT: !unordered & A<B. LE: !unordered & (A<B | equal).
//   +Inf/-Inf ordered normally; denormals compared exactly (no flush).
//  Undefined op code: accepted, result 0 (no hang, no error signal).
//  Simultaneous fill and fire on one channel: new beat takes the emptied slot.
//  r_tready may toggle arbitrarily; no result lost or duplicated.
// TESTING
//  EQ A=3F800000 B=3F800000, r_tready=1 -> r_tdata=1 exactly LATENCY cycles after join
//  EQ A=00000000 B=80000000 -> 1; LT same -> 0; LE same -> 1
//  LT A=7FC00000 (NaN) B=3F800000 -> 0; LE A=3F800000 B=7F800001 -> 0; EQ NaN,NaN -> 0
//  LT A=BF800000 B=3F800000 -> 1; LT A=C0000000 B=BF800000 -> 1; LE A=FF800000 B=7F800000 -> 1
//  op arrives 3 cycles after a,b; b arrives 2 cycles after a -> one result, correct, a/b readies low while held
//  Stream 16 random ops at 1/cycle, r_tready toggled 50% -> in-order results vs model, no loss; RST_N pulsed mid-stream -> r_tvalid=0 next cycle, no stale result

Source files
------------

// File: rtl/fp_comp_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fp_comp_responder
//
// Single-precision compare unit serving the FPU dispatcher's comp channel
// (FEQ.S / FLT.S / FLE.S). Three AXI-stream inputs (a, b, op) are joined in
// one-entry holding registers. The IEEE-754 compare is evaluated on the held
// operands and enters a LATENCY-deep stall-able pipeline. The 0/1 result
// leaves on the r channel.
//
// Handshake semantics (all channels): a beat transfers on a rising CLK edge
// where tvalid & tready are both 1. The producer keeps tdata stable while
// tvalid is high and not yet accepted. comp_r_tvalid / comp_r_tdata are held
// stable until accepted.
//
// Parameters
//   LATENCY         pipeline stages from operand join to r_tvalid (1..8)
//
// Ports
//   CLK             clock
//   RST_N           synchronous reset, active-low
//   comp_a_tdata    operand A, binary32
//   comp_a_tvalid   A valid
//   comp_a_tready   A ready
//   comp_b_tdata    operand B, binary32
//   comp_b_tvalid   B valid
//   comp_b_tready   B ready
//   comp_op_tdata   op code: 0x14 EQ, 0x0C LT, 0x1C LE (bits [7:6] ignored)
//   comp_op_tvalid  op valid
//   comp_op_tready  op ready
//   comp_r_tdata    {31'b0, result}
//   comp_r_tvalid   result valid
//   comp_r_tready   result consumer ready
// -----------------------------------------------------------------------------
module fp_comp_responder #(
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] comp_a_tdata,
    input  logic        comp_a_tvalid,
    output logic        comp_a_tready,
    input  logic [31:0] comp_b_tdata,
    input  logic        comp_b_tvalid,
    output logic        comp_b_tready,
    input  logic [7:0]  comp_op_tdata,
    input  logic        comp_op_tvalid,
    output logic        comp_op_tready,
    output logic [31:0] comp_r_tdata,
    output logic        comp_r_tvalid,
    input  logic        comp_r_tready
);

    localparam logic [5:0] OP_EQ = 6'h14;
    localparam logic [5:0] OP_LT = 6'h0C;
    localparam logic [5:0] OP_LE = 6'h1C;

    // ---------------------------------------------------------------------
    // Input holding registers
    // ---------------------------------------------------------------------
    logic        a_full;
    logic        b_full;
    logic        op_full;
    logic [31:0] a_hold;
    logic [31:0] b_hold;
    logic [5:0]  op_hold;

    logic        adv;
    logic        fire;

    // Pipeline state: one valid bit and one result bit per stage.
    logic [LATENCY-1:0] stage_valid;
    logic [LATENCY-1:0] stage_res;

    // The whole pipe freezes only when the last stage holds an unaccepted
    // result; bubbles elsewhere are squeezed out naturally as data advances.
    assign adv  = !(stage_valid[LATENCY-1] && !comp_r_tready);
    assign fire = a_full && b_full && op_full && adv;

    // A slot emptied by fire can take a new beat in the same cycle, which
    // gives one operation per cycle on back-to-back traffic.
    assign comp_a_tready  = !a_full  || fire;
    assign comp_b_tready  = !b_full  || fire;
    assign comp_op_tready = !op_full || fire;

    // The two top op-code bits carry no meaning for this unit.
    logic unused_op_bits;
    assign unused_op_bits = &{1'b0, comp_op_tdata[7:6]};

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a_full <= 1'b0;
            a_hold <= '0;
        end else if (comp_a_tvalid && comp_a_tready) begin
            a_full <= 1'b1;
            a_hold <= comp_a_tdata;
        end else if (fire) begin
            a_full <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            b_full <= 1'b0;
            b_hold <= '0;
        end else if (comp_b_tvalid && comp_b_tready) begin
            b_full <= 1'b1;
            b_hold <= comp_b_tdata;
        end else if (fire) begin
            b_full <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            op_full <= 1'b0;
            op_hold <= '0;
        end else if (comp_op_tvalid && comp_op_tready) begin
            op_full <= 1'b1;
            op_hold <= comp_op_tdata[5:0];
        end else if (fire) begin
            op_full <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // IEEE-754 compare on the held operands
    // ---------------------------------------------------------------------
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Maps a binary32 onto an unsigned key whose ordering matches the
    // numeric ordering of non-NaN values (negatives inverted so that larger
    // magnitudes sort lower, positives lifted above all negatives).
    function automatic logic [31:0] order_key(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    logic [31:0] key_a;
    logic [31:0] key_b;
    logic        unordered;
    logic        both_zero;
    logic        cmp_equal;
    logic        cmp_less;
    logic        cmp_result;

    always_comb begin
        key_a     = order_key(a_hold);
        key_b     = order_key(b_hold);
        unordered = is_nan(a_hold) || is_nan(b_hold);
        // +0 and -0 get different keys but must compare equal.
        both_zero = (a_hold[30:0] == 31'd0) && (b_hold[30:0] == 31'd0);
        cmp_equal = both_zero || (key_a == key_b);
        cmp_less  = !both_zero && (key_a < key_b);

        cmp_result = 1'b0;
        if (!unordered) begin
            case (op_hold)
                OP_EQ:   cmp_result = cmp_equal;
                OP_LT:   cmp_result = cmp_less;
                OP_LE:   cmp_result = cmp_less || cmp_equal;
                default: cmp_result = 1'b0;  // undefined op: answer 0
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Result pipeline
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stage_valid <= '0;
            stage_res   <= '0;
        end else if (adv) begin
            stage_valid[0] <= fire;
            stage_res[0]   <= fire ? cmp_result : 1'b0;
            for (int k = 1; k < LATENCY; k++) begin
                stage_valid[k] <= stage_valid[k-1];
                stage_res[k]   <= stage_res[k-1];
            end
        end
    end

    assign comp_r_tvalid = stage_valid[LATENCY-1];
    assign comp_r_tdata  = {31'd0, stage_res[LATENCY-1]};

endmodule

// File: tb/tb_fp_comp_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fp_comp_responder
//
// Directed vectors with hand-computed answers, a join-order scenario, a
// 16-op stream against a reference model with a randomly toggling consumer,
// and a mid-stream reset. Results are scoreboarded through exp_q.
// -----------------------------------------------------------------------------
module tb_fp_comp_responder;

    localparam int LAT = 2;

    // ---------------- clock / reset ----------------
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] comp_a_tdata = '0;
    logic        comp_a_tvalid = 1'b0;
    logic        comp_a_tready;
    logic [31:0] comp_b_tdata = '0;
    logic        comp_b_tvalid = 1'b0;
    logic        comp_b_tready;
    logic [7:0]  comp_op_tdata = '0;
    logic        comp_op_tvalid = 1'b0;
    logic        comp_op_tready;
    logic [31:0] comp_r_tdata;
    logic        comp_r_tvalid;
    logic        comp_r_tready = 1'b1;

    always #5 CLK = ~CLK;

    fp_comp_responder #(.LATENCY(LAT)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .comp_a_tdata   (comp_a_tdata),
        .comp_a_tvalid  (comp_a_tvalid),
        .comp_a_tready  (comp_a_tready),
        .comp_b_tdata   (comp_b_tdata),
        .comp_b_tvalid  (comp_b_tvalid),
        .comp_b_tready  (comp_b_tready),
        .comp_op_tdata  (comp_op_tdata),
        .comp_op_tvalid (comp_op_tvalid),
        .comp_op_tready (comp_op_tready),
        .comp_r_tdata   (comp_r_tdata),
        .comp_r_tvalid  (comp_r_tvalid),
        .comp_r_tready  (comp_r_tready)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks  = 0;
    int          n_pass    = 0;
    int          n_results = 0;
    logic [31:0] exp_q[$];
    logic        rand_ready   = 1'b0;
    logic        stalled_prev = 1'b0;
    logic [31:0] data_prev    = '0;

    logic [31:0] vals [14] = '{
        32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000,
        32'h4000_0000, 32'hC000_0000, 32'h7F80_0000, 32'hFF80_0000,
        32'h7FC0_0000, 32'h7F80_0001, 32'h0000_0001, 32'h8000_0001,
        32'h007F_FFFF, 32'h0080_0000
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference compare written from sign/magnitude reasoning.
    function automatic logic model(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
        logic na, nb, eq, lt;
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        if (na || nb) return 1'b0;
        if (a[30:0] == 0 && b[30:0] == 0) begin
            eq = 1'b1; lt = 1'b0;
        end else if (a[31] != b[31]) begin
            eq = 1'b0; lt = a[31];
        end else if (a == b) begin
            eq = 1'b1; lt = 1'b0;
        end else begin
            eq = 1'b0;
            lt = a[31] ? (a[30:0] > b[30:0]) : (a[30:0] < b[30:0]);
        end
        case (op[5:0])
            6'h14:   return eq;
            6'h0C:   return lt;
            6'h1C:   return lt || eq;
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CLK) begin
        if (RST_N) begin
            if (stalled_prev) begin
                check("hold_valid", comp_r_tvalid, 1);
                check("hold_data", comp_r_tdata, data_prev);
            end
            if (comp_r_tvalid && comp_r_tready) begin
                n_results++;
                check("result_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("r_tdata", comp_r_tdata, exp_q.pop_front());
            end
            stalled_prev = comp_r_tvalid && !comp_r_tready;
            data_prev    = comp_r_tdata;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    // Random consumer back-pressure.
    always @(posedge CLK) begin
        #1;
        if (rand_ready) comp_r_tready = 1'($urandom_range(0, 1));
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_all(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
        logic pa, pb, po, ta, tb, tk_op;
        int   t;
        pa = 1'b1; pb = 1'b1; po = 1'b1; t = 0;
        comp_a_tdata = a;  comp_a_tvalid  = 1'b1;
        comp_b_tdata = b;  comp_b_tvalid  = 1'b1;
        comp_op_tdata = op; comp_op_tvalid = 1'b1;
        while ((pa || pb || po) && t < 100) begin
            @(negedge CLK);
            ta    = pa && comp_a_tready;
            tb    = pb && comp_b_tready;
            tk_op = po && comp_op_tready;
            step();
            if (ta)    begin pa = 1'b0; comp_a_tvalid  = 1'b0; end
            if (tb)    begin pb = 1'b0; comp_b_tvalid  = 1'b0; end
            if (tk_op) begin po = 1'b0; comp_op_tvalid = 1'b0; end
            t++;
        end
        comp_a_tvalid = 1'b0; comp_b_tvalid = 1'b0; comp_op_tvalid = 1'b0;
        check("accept", {29'd0, pa, pb, po}, 0);
    endtask

    task automatic vec(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op, input logic e);
        exp_q.push_back({31'd0, e});
        send_all(a, b, op);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            step();
            t++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return vals[$urandom_range(0, 13)];
    endfunction

    function automatic logic [7:0] pick_op();
        logic [7:0] op;
        case ($urandom_range(0, 3))
            0:       op = 8'h14;
            1:       op = 8'h0C;
            2:       op = 8'h1C;
            default: op = 8'h00;
        endcase
        op[7:6] = 2'($urandom_range(0, 3));
        return op;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat, n0, n1;
        logic [31:0] a, b;
        logic [7:0] op;

        // reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_r_tvalid", comp_r_tvalid, 0);
        check("rst_r_tdata", comp_r_tdata, 0);
        check("rst_a_tready", comp_a_tready, 1);
        check("rst_b_tready", comp_b_tready, 1);
        check("rst_op_tready", comp_op_tready, 1);
        step();
        RST_N = 1'b1;
        step();

        // latency: all three beats accepted at one edge, result LAT cycles later
        exp_q.push_back(32'd1);
        comp_a_tdata = 32'h3F80_0000; comp_a_tvalid = 1'b1;
        comp_b_tdata = 32'h3F80_0000; comp_b_tvalid = 1'b1;
        comp_op_tdata = 8'h14;        comp_op_tvalid = 1'b1;
        @(negedge CLK);
        check("lat_rdy", {29'd0, comp_a_tready, comp_b_tready, comp_op_tready}, 7);
        step();
        comp_a_tvalid = 1'b0; comp_b_tvalid = 1'b0; comp_op_tvalid = 1'b0;
        lat = 0;
        @(negedge CLK);
        while (!comp_r_tvalid && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        check("latency", lat, LAT);
        drain();

        // directed vectors
        vec(32'h0000_0000, 32'h8000_0000, 8'h14, 1'b1);
        vec(32'h0000_0000, 32'h8000_0000, 8'h0C, 1'b0);
        vec(32'h0000_0000, 32'h8000_0000, 8'h1C, 1'b1);
        vec(32'h7FC0_0000, 32'h3F80_0000, 8'h0C, 1'b0);
        vec(32'h3F80_0000, 32'h7F80_0001, 8'h1C, 1'b0);
        vec(32'h7FC0_0000, 32'h7FC0_0000, 8'h14, 1'b0);
        vec(32'hBF80_0000, 32'h3F80_0000, 8'h0C, 1'b1);
        vec(32'hC000_0000, 32'hBF80_0000, 8'h0C, 1'b1);
        vec(32'hFF80_0000, 32'h7F80_0000, 8'h1C, 1'b1);
        vec(32'h3F80_0000, 32'h3F80_0000, 8'h0C, 1'b0);
        vec(32'h3F80_0000, 32'h3F80_0000, 8'h1C, 1'b1);
        vec(32'h0000_0001, 32'h0000_0002, 8'h0C, 1'b1);
        vec(32'h8000_0002, 32'h8000_0001, 8'h0C, 1'b1);
        vec(32'h7F80_0000, 32'h7F80_0000, 8'h14, 1'b1);
        vec(32'h4000_0000, 32'h3F80_0000, 8'h0C, 1'b0);
        vec(32'h3F80_0000, 32'h3F80_0000, 8'h00, 1'b0);
        vec(32'h3F80_0000, 32'h3F80_0000, 8'hD4, 1'b1);
        drain();

        // join order: a, then b two cycles later, then op three cycles after b
        n0 = n_results;
        exp_q.push_back(32'd1);
        comp_a_tdata = 32'h3F80_0000; comp_a_tvalid = 1'b1;
        @(negedge CLK);
        check("join_a_rdy", comp_a_tready, 1);
        step();
        comp_a_tvalid = 1'b0;
        @(negedge CLK);
        check("join_a_held", comp_a_tready, 0);
        step();
        comp_b_tdata = 32'h4000_0000; comp_b_tvalid = 1'b1;
        @(negedge CLK);
        check("join_b_rdy", comp_b_tready, 1);
        step();
        comp_b_tvalid = 1'b0;
        @(negedge CLK);
        check("join_ab_held", {30'd0, comp_a_tready, comp_b_tready}, 0);
        check("join_no_r", comp_r_tvalid, 0);
        step();
        @(negedge CLK);
        check("join_ab_held2", {30'd0, comp_a_tready, comp_b_tready}, 0);
        step();
        comp_op_tdata = 8'h0C; comp_op_tvalid = 1'b1;
        @(negedge CLK);
        check("join_op_rdy", comp_op_tready, 1);
        step();
        comp_op_tvalid = 1'b0;
        drain();
        repeat (4) step();
        check("join_one_result", n_results - n0, 1);

        // 16-op stream against the model with random back-pressure
        n0 = n_results;
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = pick();
            b = ($urandom_range(0, 3) == 0) ? a : pick();
            op = pick_op();
            vec(a, b, op, model(a, b, op));
        end
        drain();
        rand_ready = 1'b0;
        comp_r_tready = 1'b1;
        repeat (3) step();
        check("stream_count", n_results - n0, 16);

        // reset mid-stream: in-flight work vanishes
        rand_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = pick();
            b = pick();
            op = pick_op();
            vec(a, b, op, model(a, b, op));
        end
        rand_ready = 1'b0;
        comp_r_tready = 1'b0;
        RST_N = 1'b0;
        exp_q.delete();
        step();
        RST_N = 1'b1;
        comp_r_tready = 1'b1;
        @(negedge CLK);
        check("midrst_r_tvalid", comp_r_tvalid, 0);
        check("midrst_r_tdata", comp_r_tdata, 0);
        check("midrst_rdy", {29'd0, comp_a_tready, comp_b_tready, comp_op_tready}, 7);
        n1 = n_results;
        repeat (6) step();
        check("midrst_no_stale", n_results - n1, 0);
        vec(32'hBF80_0000, 32'h8000_0000, 8'h1C, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
